// File: rtl/cosa_seq_ctrl.sv
// Chunk-serial wide adder: one exact CHUNK-bit carry-skip adder reused LSB chunk first,
// carry registered between chunks. Define COSA_SEQ_CLKGATE_EN to drive adder_en from RUN only.

module param_cosa #(
  parameter int W      = 8,
  parameter int BLK    = 4,
  parameter int APPROX = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NBLK = W / BLK;

  logic c_s;
  logic rc_s;
  logic p_s;

  // Ripple inside each block; a fully propagating block forwards its carry-in unchanged.
  always_comb begin
    sum  = '0;
    c_s  = cin;
    rc_s = 1'b0;
    p_s  = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      rc_s = c_s;
      p_s  = 1'b1;
      for (int j = 0; j < BLK; j++) begin
        sum[k*BLK+j] = a[k*BLK+j] ^ b[k*BLK+j] ^ rc_s;
        p_s          = p_s & (a[k*BLK+j] ^ b[k*BLK+j]);
        rc_s         = (a[k*BLK+j] & b[k*BLK+j]) | ((a[k*BLK+j] ^ b[k*BLK+j]) & rc_s);
      end
      if (APPROX != 0) begin
        // Speculative carry from the block MSB generate only.
        c_s = a[k*BLK+BLK-1] & b[k*BLK+BLK-1];
      end else begin
        c_s = p_s ? c_s : rc_s;
      end
    end
    cout = c_s;
  end
endmodule

module cosa_seq_ctrl #(
  parameter int TOTAL_W = 32,
  parameter int CHUNK   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] a,
  input  logic [TOTAL_W-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] sum,
  output logic               cout,
  output logic               busy,
  output logic               adder_en
);
  localparam int NCHUNK   = TOTAL_W / CHUNK;
  localparam int IDX_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SKIP_BLK = ((CHUNK % 4) == 0) ? 4 : CHUNK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (((TOTAL_W % CHUNK) != 0) || (NCHUNK < 2)) begin : g_bad_cfg
    $error("cosa_seq_ctrl: TOTAL_W must be a multiple of CHUNK giving at least two chunks");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic               last_s;
  logic [IDX_W-1:0]   idx_r;
  logic               cy_r;
  logic [TOTAL_W-1:0] a_r;
  logic [TOTAL_W-1:0] b_r;
  logic [TOTAL_W-1:0] sum_r;
  logic               cout_r;
  logic [CHUNK-1:0]   a_chunk_s;
  logic [CHUNK-1:0]   b_chunk_s;
  logic [CHUNK-1:0]   chunk_sum_s;
  logic               chunk_cout_s;

  assign a_chunk_s = a_r[int'(idx_r)*CHUNK +: CHUNK];
  assign b_chunk_s = b_r[int'(idx_r)*CHUNK +: CHUNK];

  param_cosa #(
    .W      (CHUNK),
    .BLK    (SKIP_BLK),
    .APPROX (0)
  ) u_adder (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (cy_r),
    .sum  (chunk_sum_s),
    .cout (chunk_cout_s)
  );

  // Next-state decode; accept and last-chunk strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and chunk-serial accumulation; registers idle outside accept/RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r  <= '0;
      cy_r   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      cy_r  <= cin;
      idx_r <= '0;
    end else if (state_r == RUN) begin
      sum_r[int'(idx_r)*CHUNK +: CHUNK] <= chunk_sum_s;
      cy_r <= chunk_cout_s;
      if (last_s) begin
        cout_r <= chunk_cout_s;
        idx_r  <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // rst masks in_ready so no handshake can complete while reset is held.
  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;

`ifdef COSA_SEQ_CLKGATE_EN
  assign adder_en = (state_r == RUN);
`else
  assign adder_en = 1'b1;
`endif

endmodule

// File: tb/tb_cosa_seq_ctrl.sv
// Scoreboard bench for cosa_seq_ctrl (TOTAL_W=32, CHUNK=8) with directed operand vectors.
`timescale 1ns/1ps

module tb_cosa_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;
  logic        adder_en;

`ifdef COSA_SEQ_CLKGATE_EN
  localparam int EN_PER_OP = 4;
  localparam bit EN_IDLE   = 1'b0;
`else
  localparam int EN_PER_OP = 5;
  localparam bit EN_IDLE   = 1'b1;
`endif

  cosa_seq_ctrl #(.TOTAL_W(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
    .adder_en  (adder_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [32:0] exp_q[$];
  string       name_q[$];
  int          en_cnt = 0;
  int          rise_cyc = 0;
  int          en_at_rise = 0;
  logic        prev_ov = 1'b0;

  // Monitor: pops the scoreboard on every completed output handshake.
  initial begin
    logic [32:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (adder_en === 1'b1) en_cnt++;
      if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
        rise_cyc   = cyc;
        en_at_rise = en_cnt;
      end
      prev_ov = out_valid;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got sum=%h cout=%b, required no result", sum, cout);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if ({cout, sum} !== e) begin
            errors++;
            $display("FAIL %s: got sum=%h cout=%b, required sum=%h cout=%b",
                     n, sum, cout, e[31:0], e[32]);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, got, expv);
    end
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                      input bit push, input logic [32:0] expv, input string n,
                      output int acc_cyc, output int acc_en);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    acc_cyc = cyc;
    acc_en  = en_cnt;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got no accept, required accept within 40 cycles", n);
    end else if (push) begin
      exp_q.push_back(expv);
      name_q.push_back(n);
    end
  endtask

  task automatic drain(input string n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending results, required 0", n, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc1, acc2, en1, en2;
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 32'h0;
    b = 32'h0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_ready_during_rst", {63'h0, in_ready}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {out_valid, in_ready, busy, cout, sum}, {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    chk("reset_adder_en", {63'h0, adder_en}, {63'h0, EN_IDLE});
    @(posedge clk);
    #1;

    // Basic carry across the first chunk boundary, with latency and enable count.
    send(32'h000000FF, 32'h00000001, 1'b0, 1'b1, {1'b0, 32'h00000100}, "ff_plus_1", acc1, en1);
    drain("ff_plus_1");
    chk("latency", 64'(rise_cyc - acc1), 64'd4);
    chk("adder_en_per_op", 64'(en_at_rise - en1), 64'(EN_PER_OP));

    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, {1'b1, 32'h00000000}, "ripple_all", acc1, en1);
    drain("ripple_all");

    send(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 1'b1, {1'b1, 32'h00000000}, "skip_all", acc1, en1);
    drain("skip_all");

    // Back-to-back operations with out_ready held high.
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, {1'b1, 32'hFFFFFFFF}, "all_ones", acc1, en1);
    send(32'h12345678, 32'h11111111, 1'b0, 1'b1, {1'b0, 32'h23456789}, "b2b_second", acc2, en2);
    chk("b2b_period", 64'(acc2 - acc1), 64'd6);
    drain("b2b");

    // Backpressure: DONE held with new operands offered.
    out_ready = 1'b0;
    send(32'h80000000, 32'h80000000, 1'b1, 1'b1, {1'b1, 32'h00000001}, "backpressure", acc1, en1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("bp_reach_done", {63'h0, seen}, 64'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 32'hDEADBEEF;
    b = 32'hCAFEF00D;
    cin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", {adder_en, out_valid, in_ready, busy, cout, sum},
          {~EN_IDLE ^ 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000001});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("backpressure");
    @(negedge clk);
    chk("bp_no_capture", {61'h0, busy, in_ready, out_valid}, {61'h0, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #1;

    // Reset during RUN discards the operation.
    send(32'h00000003, 32'h00000004, 1'b0, 1'b0, 33'h0, "aborted", acc1, en1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state", {out_valid, in_ready, busy, cout, sum}, {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    chk("abort_adder_en", {63'h0, adder_en}, {63'h0, EN_IDLE});
    @(posedge clk);
    #1;
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 32'h0000000C}, "after_abort", acc1, en1);
    drain("after_abort");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
